// File: rtl/ex_pipe_ctrl_if.sv
// rtl/ex_pipe_ctrl_if.sv - decode/execute/memory handshake bundle for ex_pipe_ctrl
interface ex_pipe_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_id_valid;
  logic            o_id_ready;
  logic [4:0]      i_id_rd;
  logic [4:0]      i_id_rs1;
  logic [4:0]      i_id_rs2;
  logic            i_id_rs1_used;
  logic            i_id_rs2_used;
  logic            i_id_is_load;
  logic            o_ex_load;
  logic            i_ex_pc_load;
  logic [XLEN-1:0] i_ex_pc_ext;
  logic            o_mem_valid;
  logic            i_mem_ready;
  logic            o_redirect_valid;
  logic [XLEN-1:0] o_redirect_pc;
  logic [31:0]     o_perf_retired;
  logic [31:0]     o_perf_bubbles;
  logic [31:0]     o_perf_flushes;

  modport master (
    output i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_is_load, i_ex_pc_load, i_ex_pc_ext, i_mem_ready,
    input  o_id_ready, o_ex_load, o_mem_valid, o_redirect_valid, o_redirect_pc,
           o_perf_retired, o_perf_bubbles, o_perf_flushes
  );

  modport slave (
    input  i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_is_load, i_ex_pc_load, i_ex_pc_ext, i_mem_ready,
    output o_id_ready, o_ex_load, o_mem_valid, o_redirect_valid, o_redirect_pc,
           o_perf_retired, o_perf_bubbles, o_perf_flushes
  );
endinterface

// File: rtl/ex_pipe_ctrl.sv
// rtl/ex_pipe_ctrl.sv - EX stage control: load-use stall, branch redirect and flush
// Optional performance counters are built when EX_PERF_CNT_EN is defined.
module ex_pipe_ctrl #(
  parameter int FLUSH_DEPTH = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ex_pipe_ctrl_if.slave  bus
);
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [1:0] FLUSH_CNT_INIT = 2'(FLUSH_DEPTH - 1);

  state_t     state;
  logic [1:0] flush_cnt;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_is_load;

  logic adv;
  logic haz;
  logic redir;
  logic id_ready;
  logic xfer;
  logic kill;
  logic ex_load;

  assign adv = !ex_valid || bus.i_mem_ready;

  assign haz = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((bus.i_id_rs1_used && (bus.i_id_rs1 == ex_rd)) ||
                (bus.i_id_rs2_used && (bus.i_id_rs2 == ex_rd)));

  // A stalled branch only redirects once MEM takes it, so it fires exactly once.
  assign redir    = (state == RUN) && ex_valid && bus.i_ex_pc_load && bus.i_mem_ready;
  assign id_ready = (state == FLUSH) ? 1'b1 : (adv && !haz);
  assign xfer     = bus.i_id_valid && id_ready;
  assign kill     = redir || (state == FLUSH);
  assign ex_load  = xfer && !kill && !i_rst;

  assign bus.o_id_ready       = id_ready;
  assign bus.o_ex_load        = ex_load;
  assign bus.o_mem_valid      = ex_valid;
  assign bus.o_redirect_valid = redir;
  assign bus.o_redirect_pc    = bus.i_ex_pc_ext;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= RUN;
      flush_cnt  <= 2'd0;
      ex_valid   <= 1'b0;
      ex_rd      <= 5'd0;
      ex_is_load <= 1'b0;
    end else begin
      if (ex_load) begin
        ex_valid   <= 1'b1;
        ex_rd      <= bus.i_id_rd;
        ex_is_load <= bus.i_id_is_load;
      end else if (adv) begin
        ex_valid <= 1'b0;
      end

      // The redirect cycle is the first killed slot; FLUSH covers the rest.
      case (state)
        RUN: begin
          if (redir && (FLUSH_DEPTH > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_CNT_INIT;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt - 2'd1;
          if (flush_cnt == 2'd1) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef EX_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_retired <= 32'd0;
      perf_bubbles <= 32'd0;
      perf_flushes <= 32'd0;
    end else begin
      if (ex_valid && bus.i_mem_ready) perf_retired <= perf_retired + 32'd1;
      if (haz && bus.i_id_valid)       perf_bubbles <= perf_bubbles + 32'd1;
      if (redir)                       perf_flushes <= perf_flushes + 32'd1;
    end
  end

  assign bus.o_perf_retired = perf_retired;
  assign bus.o_perf_bubbles = perf_bubbles;
  assign bus.o_perf_flushes = perf_flushes;
`else
  assign bus.o_perf_retired = 32'd0;
  assign bus.o_perf_bubbles = 32'd0;
  assign bus.o_perf_flushes = 32'd0;
`endif
endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// tb/tb_ex_pipe_ctrl.sv - scoreboard bench for ex_pipe_ctrl (FLUSH_DEPTH=2)
module tb_ex_pipe_ctrl;
  logic clk = 1'b1;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ex_pipe_ctrl_if #(.XLEN(32)) bus ();

  ex_pipe_ctrl #(.FLUSH_DEPTH(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

`ifdef EX_PERF_CNT_EN
  localparam logic [31:0] PMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PMASK = 32'h0000_0000;
`endif

  typedef struct {
    string       name;
    logic        idr;
    logic        exl;
    logic        mv;
    logic        rv;
    logic [31:0] pc;
    bit          chk_perf;
    logic [31:0] r;
    logic [31:0] b;
    logic [31:0] f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one expected vector per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk({mon_e.name, ".id_ready"}, 32'(bus.o_id_ready), 32'(mon_e.idr));
      chk({mon_e.name, ".ex_load"}, 32'(bus.o_ex_load), 32'(mon_e.exl));
      chk({mon_e.name, ".mem_valid"}, 32'(bus.o_mem_valid), 32'(mon_e.mv));
      chk({mon_e.name, ".redirect_valid"}, 32'(bus.o_redirect_valid), 32'(mon_e.rv));
      if (mon_e.rv) chk({mon_e.name, ".redirect_pc"}, bus.o_redirect_pc, mon_e.pc);
      if (mon_e.chk_perf) begin
        chk({mon_e.name, ".perf_retired"}, bus.o_perf_retired, mon_e.r);
        chk({mon_e.name, ".perf_bubbles"}, bus.o_perf_bubbles, mon_e.b);
        chk({mon_e.name, ".perf_flushes"}, bus.o_perf_flushes, mon_e.f);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u1, input logic u2, input logic ld,
                     input logic pcl, input logic [31:0] pce, input logic mr);
    bus.i_id_valid    = v;
    bus.i_id_rd       = rd;
    bus.i_id_rs1      = rs1;
    bus.i_id_rs2      = rs2;
    bus.i_id_rs1_used = u1;
    bus.i_id_rs2_used = u2;
    bus.i_id_is_load  = ld;
    bus.i_ex_pc_load  = pcl;
    bus.i_ex_pc_ext   = pce;
    bus.i_mem_ready   = mr;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic push(input string n, input logic idr, input logic exl, input logic mv,
                      input logic rv, input logic [31:0] pc, input bit cp,
                      input logic [31:0] r, input logic [31:0] b, input logic [31:0] f);
    exp_t e;
    e.name = n; e.idr = idr; e.exl = exl; e.mv = mv; e.rv = rv; e.pc = pc;
    e.chk_perf = cp; e.r = r & PMASK; e.b = b & PMASK; e.f = f & PMASK;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string n, input logic idr, input logic exl, input logic mv,
                     input logic rv, input logic [31:0] pc);
    push(n, idr, exl, mv, rv, pc, 1'b0, 32'd0, 32'd0, 32'd0);
    step();
  endtask

  task automatic cycp(input string n, input logic idr, input logic exl, input logic mv,
                      input logic rv, input logic [31:0] pc,
                      input logic [31:0] r, input logic [31:0] b, input logic [31:0] f);
    push(n, idr, exl, mv, rv, pc, 1'b1, r, b, f);
    step();
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    drv(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycp("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // First transfer out of reset
    drv(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc("first_xfer", 1, 1, 0, 0, 0);
    idle(); cyc("first_mem", 1, 0, 1, 0, 0);
    idle(); cycp("idle0", 1, 0, 0, 0, 0, 1, 0, 0);

    // LW x5 ; ADD x6,x5,x1
    drv(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cyc("lw_x5", 1, 1, 0, 0, 0);
    drv(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cycp("add_stall", 0, 0, 1, 0, 0, 1, 0, 0);
    cycp("add_load", 1, 1, 0, 0, 0, 2, 1, 0);
    idle(); cyc("add_mem", 1, 0, 1, 0, 0);

    // LW x0 ; consumer of x0 must not stall
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycp("lw_x0", 1, 1, 0, 0, 0, 3, 1, 0);
    drv(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc("use_x0", 1, 1, 1, 0, 0);
    idle(); cyc("use_x0_mem", 1, 0, 1, 0, 0);

    // LW x9 ; consumer through rs2 only
    drv(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cycp("lw_x9", 1, 1, 0, 0, 0, 5, 1, 0);
    drv(1'b1, 5'd10, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc("rs2_stall", 0, 0, 1, 0, 0);
    cycp("rs2_load", 1, 1, 0, 0, 0, 6, 2, 0);
    idle(); cyc("rs2_mem", 1, 0, 1, 0, 0);
    idle(); cycp("idle1", 1, 0, 0, 0, 0, 7, 2, 0);

    // Taken branch to 0x100: redirect slot plus one flush slot dropped
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    cyc("br_enter", 1, 1, 0, 0, 0);
    drv(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    cycp("br_redir", 1, 0, 1, 1, 32'h100, 7, 2, 0);
    drv(1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    cyc("flush_drop", 1, 0, 0, 0, 0);
    drv(1'b1, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycp("post_flush", 1, 1, 0, 0, 0, 8, 2, 1);
    idle(); cyc("post_flush_mem", 1, 0, 1, 0, 0);
    idle(); cycp("idle2", 1, 0, 0, 0, 0, 9, 2, 1);

    // Branch held by MEM backpressure for 3 cycles
    drv(1'b1, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    cyc("bp_enter", 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
      cyc("bp_hold", 0, 0, 1, 0, 0);
    end
    drv(1'b1, 5'd16, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1);
    cycp("bp_redir", 1, 0, 1, 1, 32'h200, 9, 2, 1);
    idle(); cyc("bp_flush", 1, 0, 0, 0, 0);
    drv(1'b1, 5'd17, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycp("bp_resume", 1, 1, 0, 0, 0, 10, 2, 2);
    idle(); cyc("bp_resume_mem", 1, 0, 1, 0, 0);

    // Async reset while flushing
    drv(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    cycp("rst_br_enter", 1, 1, 0, 0, 0, 11, 2, 2);
    drv(1'b1, 5'd19, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1);
    cyc("rst_br_redir", 1, 0, 1, 1, 32'h300);
    drv(1'b1, 5'd19, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    push("rst_mid", 1, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.mem_valid", 32'(bus.o_mem_valid), 32'd0);
    chk("async_rst.ex_load", 32'(bus.o_ex_load), 32'd0);
    chk("async_rst.redirect_valid", 32'(bus.o_redirect_valid), 32'd0);
    chk("async_rst.id_ready", 32'(bus.o_id_ready), 32'd1);
    chk("async_rst.perf_flushes", bus.o_perf_flushes, 32'd0);
    chk("async_rst.perf_retired", bus.o_perf_retired, 32'd0);
    step();
    rst = 1'b0;
    drv(1'b1, 5'd18, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycp("rst_resume", 1, 1, 0, 0, 0, 0, 0, 0);
    idle(); cyc("rst_resume_mem", 1, 0, 1, 0, 0);
    idle(); cycp("idle3", 1, 0, 0, 0, 0, 1, 0, 0);

    // Redirect and load-use hazard in the same cycle
    drv(1'b1, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    cyc("ldbr_enter", 1, 1, 0, 0, 0);
    drv(1'b1, 5'd21, 5'd20, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1);
    cycp("haz_redir", 0, 0, 1, 1, 32'h400, 1, 0, 0);
    drv(1'b1, 5'd21, 5'd20, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cyc("haz_flush", 1, 0, 0, 0, 0);
    cycp("haz_resume", 1, 1, 0, 0, 0, 2, 1, 1);
    idle(); cyc("haz_resume_mem", 1, 0, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_pipe_ctrl.md
EX_PIPE_CTRL -- requirements
Module: ex_pipe_ctrl

Interface
REQ-001 Parameter: FLUSH_DEPTH, default 2, is the number of younger instruction slots killed per taken redirect, counting the redirect cycle itself; legal range 1..3.
REQ-002 Port: i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 Port: i_id_valid  input  1  the decode stage offers an instruction.
REQ-005 Port: o_id_ready  output  1  the controller accepts the offered decode instruction this cycle.
REQ-006 Port: i_id_rd, i_id_rs1, i_id_rs2  input  5 each  register addresses of the offered instruction.
REQ-007 Port: i_id_rs1_used, i_id_rs2_used  input  1 each  the offered instruction reads rs1 or rs2.
REQ-008 Port: i_id_is_load  input  1  the offered instruction is a load (mem set, iop clear).
REQ-009 Port: o_ex_load  output  1  load enable for the EX pipeline register (control_ex_s, rs1, rs2, imm, pc).
REQ-010 Port: i_ex_pc_load, i_ex_pc_ext  input  1 / XLEN  branch-taken flag and target from the execute datapath for the instruction in EX.
REQ-011 Port: o_mem_valid  output  1  the EX slot holds a valid instruction for MEM.
REQ-012 Port: i_mem_ready  input  1  MEM accepts the EX result this cycle.
REQ-013 Port: o_redirect_valid, o_redirect_pc  output  1 / XLEN  fetch redirect request and its target.
REQ-014 Port: o_perf_retired, o_perf_bubbles, o_perf_flushes  output  32 each  performance counters.

Function
REQ-015 State: ex_valid, ex_rd[4:0], ex_is_load, a two-state FSM {RUN, FLUSH}, and a 2-bit flush counter.
REQ-016 EX advance (adv) = !ex_valid | i_mem_ready; o_mem_valid = ex_valid.
REQ-017 Hazard (haz) = ex_valid & ex_is_load & ex_rd!=0 & ((i_id_rs1_used & i_id_rs1==ex_rd) | (i_id_rs2_used & i_id_rs2==ex_rd)).
REQ-018 Redirect (redir) = (state==RUN) & ex_valid & i_ex_pc_load & i_mem_ready; o_redirect_valid = redir and o_redirect_pc = i_ex_pc_ext, both combinational.
REQ-019 o_id_ready = 1 in FLUSH; otherwise o_id_ready = adv & !haz.
REQ-020 Transfer (xfer) = i_id_valid & o_id_ready; kill = redir | (state==FLUSH); o_ex_load = xfer & !kill.
REQ-021 Next ex_valid: set to 1 on o_ex_load; else cleared to 0 when adv; else held.
REQ-022 ex_rd and ex_is_load load from i_id_rd and i_id_is_load only on o_ex_load.
REQ-023 A load-use hazard inserts exactly one bubble: the load moves to MEM while EX empties; haz is then 0 and the dependent instruction transfers on the next cycle.
REQ-024 If i_mem_ready=0 while a taken branch is in EX, hold the branch, keep redir=0, and fire redir in the first cycle i_mem_ready=1; redir is asserted exactly once per branch.
REQ-025 RUN->FLUSH on redir when FLUSH_DEPTH>1, loading counter = FLUSH_DEPTH-1; with FLUSH_DEPTH=1, stay in RUN.
REQ-026 In FLUSH the counter decrements each cycle; FLUSH->RUN when the counter is 1. Transfers in FLUSH are accepted and discarded, whether or not i_id_valid is set.
REQ-027 Redirect and hazard in the same cycle: redir takes priority, and the decode instruction is not accepted (haz forces o_id_ready=0).

Reset
REQ-028 i_rst asynchronously forces ex_valid=0, ex_rd=0, ex_is_load=0, state=RUN, counter=0, and all perf counters=0.
REQ-029 During reset, o_mem_valid=0, o_ex_load=0 and o_redirect_valid=0; o_id_ready follows REQ-019 (1, since EX is empty).
REQ-030 Reset asserted mid-FLUSH abandons the flush; the first cycle after reset is RUN.

Configuration
REQ-031 Macro: EX_PERF_CNT_EN.
REQ-032 When EX_PERF_CNT_EN is defined: o_perf_retired increments on ex_valid & i_mem_ready; o_perf_bubbles increments on haz & i_id_valid; o_perf_flushes increments on redir. All three counters wrap at 2^32.
REQ-033 When EX_PERF_CNT_EN is undefined: no counter flops are built and all three perf outputs are tied to 0.

Verification
REQ-034 Reset check: after reset, drive i_id_valid=1 with i_mem_ready=1 -> o_id_ready=1, o_ex_load=1, and o_mem_valid=1 on the next cycle.
REQ-035 Load-use: LW x5 followed by ADD x6,x5,x1 -> one cycle with o_id_ready=0 and o_perf_bubbles=1, then ADD loads; LW x0 followed by a consumer of x0 -> no stall.
REQ-036 Taken branch: i_ex_pc_load=1, i_ex_pc_ext=0x0000_0100, FLUSH_DEPTH=2 -> o_redirect_valid pulses for 1 cycle with pc 0x100; the next 2 decode slots are dropped (o_ex_load=0); the third slot loads.
REQ-037 Backpressure: taken branch in EX with i_mem_ready=0 for 3 cycles -> no redirect and o_id_ready=0; redirect fires in the cycle i_mem_ready rises, exactly once.
REQ-038 Async reset mid-FLUSH: assert i_rst between clock edges -> all outputs clear immediately; after release, normal transfer with no residual kill.
REQ-039 Build without EX_PERF_CNT_EN: rerun REQ-035 and REQ-036 -> identical control behaviour, with all perf outputs 0.
